// File: rtl/tour_pkg.sv
// Shared definitions for the tour command path: opcodes, command word
// field positions and the executor state type.
package tour_pkg;

  // Opcodes; anything else decodes as a NOP
  localparam logic [3:0] OP_MOVE    = 4'h2;
  localparam logic [3:0] OP_MOVE_FF = 4'h3;

  // Command word layout: [15:12] opcode, [11:4] heading, [3:0] squares
  localparam int unsigned CMD_OP_MSB  = 15;
  localparam int unsigned CMD_OP_LSB  = 12;
  localparam int unsigned CMD_HDG_MSB = 11;
  localparam int unsigned CMD_HDG_LSB = 4;
  localparam int unsigned CMD_SQ_MSB  = 3;
  localparam int unsigned CMD_SQ_LSB  = 0;

  // Executor states, legacy encodings kept explicit
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_MOVE    = 3'd2,
    ST_FANFARE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // True for the opcodes that drive the robot across squares
  function automatic logic is_move_op(input logic [3:0] op);
    return (op == OP_MOVE) || (op == OP_MOVE_FF);
  endfunction

endpackage

// File: rtl/sq_timer.sv
// Loadable 16-bit down-counter. tc pulses for one cycle when the
// counter is enabled and sitting at zero; the owner reloads it then.
module sq_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        tc
);

  logic [15:0] cnt;

  // Load has priority; otherwise count down while enabled, holding at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 16'd0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tc = en && (cnt == 16'd0);

endmodule

// File: rtl/move_cmd_exec.sv
// Executes MOVE / MOVE_FF / NOP commands from TourCmd: latches the
// command, times each square, optionally holds a fanfare, then pulses
// send_resp. Define FANFARE_EN to enable the fanfare after MOVE_FF;
// without it MOVE_FF behaves as MOVE and fanfare is tied low.
module move_cmd_exec
  import tour_pkg::*;
#(
  parameter logic [15:0] SQ_CYCLES      = 16'd1000,
  parameter logic [15:0] FANFARE_CYCLES = 16'd500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic        moving,
  output logic [7:0]  heading,
  output logic        sq_done,
  output logic        fanfare
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cmd_q;
  logic [3:0]  op_q;
  logic [3:0]  sq_q;
  logic [3:0]  sq_left;
  logic [7:0]  heading_q;
  logic        last_sq;
  logic        go_fanfare;
  logic        tmr_load;
  logic        tmr_en;
  logic [15:0] tmr_load_val;
  logic        tmr_tc;

  assign op_q    = cmd_q[CMD_OP_MSB:CMD_OP_LSB];
  assign sq_q    = cmd_q[CMD_SQ_MSB:CMD_SQ_LSB];
  assign last_sq = (sq_left == 4'd1);

`ifdef FANFARE_EN
  assign go_fanfare = (op_q == OP_MOVE_FF);
`else
  assign go_fanfare = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cmd_rdy) state_nxt = ST_DECODE;
      ST_DECODE:  state_nxt = (is_move_op(op_q) && (sq_q != 4'd0)) ? ST_MOVE : ST_RESP;
      ST_MOVE:    if (tmr_tc && last_sq) state_nxt = go_fanfare ? ST_FANFARE : ST_RESP;
`ifdef FANFARE_EN
      ST_FANFARE: if (tmr_tc) state_nxt = ST_RESP;
`endif
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Command latch, square countdown and heading register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      sq_left   <= '0;
      heading_q <= '0;
    end else begin
      if ((state == ST_IDLE) && cmd_rdy) cmd_q <= cmd;
      if (state == ST_DECODE) begin
        sq_left <= sq_q;
        if (is_move_op(op_q)) heading_q <= cmd_q[CMD_HDG_MSB:CMD_HDG_LSB];
      end else if ((state == ST_MOVE) && tmr_tc) begin
        sq_left <= sq_left - 4'd1;
      end
    end
  end

  // One down-counter serves both square and fanfare timing: it is armed
  // in DECODE, rearmed at every square end, and on the last square of a
  // fanfare move it is rearmed with the fanfare length instead.
  assign tmr_load     = (state == ST_DECODE) || ((state == ST_MOVE) && tmr_tc);
  assign tmr_load_val = ((state == ST_MOVE) && last_sq && go_fanfare) ?
                        (FANFARE_CYCLES - 16'd1) : (SQ_CYCLES - 16'd1);
  assign tmr_en       = (state == ST_MOVE) || (state == ST_FANFARE);

  sq_timer u_sq_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  assign clr_cmd_rdy = (state == ST_DECODE);
  assign send_resp   = (state == ST_RESP);
  assign moving      = (state == ST_MOVE);
  assign sq_done     = (state == ST_MOVE) && tmr_tc;
  assign heading     = heading_q;
`ifdef FANFARE_EN
  assign fanfare     = (state == ST_FANFARE);
`else
  assign fanfare     = 1'b0;
`endif

endmodule

// File: tb/tb_move_cmd_exec.sv
// Directed bench for move_cmd_exec with SQ_CYCLES=8, FANFARE_CYCLES=4.
// Cycle 0 is the first cycle the idle block sees cmd_rdy high.
module tb_move_cmd_exec;

  logic        clk;
  logic        rst_n;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        moving;
  logic [7:0]  heading;
  logic        sq_done;
  logic        fanfare;

  int n_total;
  int n_bad;

  int clr_cyc[4];
  int resp_cyc[4];
  int sqd_cyc[8];
  int n_clr, n_resp, n_sqd;
  int mov_first, n_mov;
  int fan_first, n_fan;

  move_cmd_exec #(
    .SQ_CYCLES      (16'd8),
    .FANFARE_CYCLES (16'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .moving      (moving),
    .heading     (heading),
    .sq_done     (sq_done),
    .fanfare     (fanfare)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the block idle. Presents c1,
  // optionally raises c2 at the start of cycle raise2, drops cmd_rdy
  // after each clr_cmd_rdy, and logs output activity per cycle.
  task automatic observe(input logic [15:0] c1, input int n,
                         input int raise2, input logic [15:0] c2);
    logic drop;
    n_clr = 0; n_resp = 0; n_sqd = 0;
    mov_first = -1; n_mov = 0;
    fan_first = -1; n_fan = 0;
    for (int i = 0; i < 4; i++) begin clr_cyc[i] = -1; resp_cyc[i] = -1; end
    for (int i = 0; i < 8; i++) sqd_cyc[i] = -1;
    cmd = c1;
    cmd_rdy = 1'b1;
    for (int c = 0; c < n; c++) begin
      if ((c == raise2) && (c > 0)) begin
        cmd = c2;
        cmd_rdy = 1'b1;
      end
      @(negedge clk);
      if (clr_cmd_rdy) begin if (n_clr < 4) clr_cyc[n_clr] = c; n_clr++; end
      if (send_resp) begin if (n_resp < 4) resp_cyc[n_resp] = c; n_resp++; end
      if (sq_done) begin if (n_sqd < 8) sqd_cyc[n_sqd] = c; n_sqd++; end
      if (moving) begin if (mov_first < 0) mov_first = c; n_mov++; end
      if (fanfare) begin if (fan_first < 0) fan_first = c; n_fan++; end
      drop = clr_cmd_rdy;
      @(posedge clk);
      #1;
      if (drop) cmd_rdy = 1'b0;
    end
  endtask

  initial begin
    logic any_act;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    cmd     = 16'h2003;
    cmd_rdy = 1'b1;

    // Reset holds everything low even with a command waiting
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clr", clr_cmd_rdy, 0);
    chk("rst_resp", send_resp, 0);
    chk("rst_moving", moving, 0);
    chk("rst_heading", heading, 0);
    chk("rst_sqdone", sq_done, 0);
    chk("rst_fanfare", fanfare, 0);
    @(posedge clk); #1;
    cmd_rdy = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Three-square MOVE
    observe(16'h2003, 30, -1, 16'h0);
    chk("m3_clr_n", n_clr, 1);
    chk("m3_clr_cyc", clr_cyc[0], 1);
    chk("m3_heading", heading, 8'h00);
    chk("m3_sqd_n", n_sqd, 3);
    chk("m3_sqd0", sqd_cyc[0], 9);
    chk("m3_sqd1", sqd_cyc[1], 17);
    chk("m3_sqd2", sqd_cyc[2], 25);
    chk("m3_resp_n", n_resp, 1);
    chk("m3_resp_cyc", resp_cyc[0], 26);
    chk("m3_mov_first", mov_first, 2);
    chk("m3_mov_n", n_mov, 24);
    chk("m3_fan_n", n_fan, 0);

    // Two-square MOVE_FF
    observe(16'h3A52, 26, -1, 16'h0);
    chk("ff_heading", heading, 8'hA5);
    chk("ff_mov_n", n_mov, 16);
    chk("ff_sqd1", sqd_cyc[1], 17);
`ifdef FANFARE_EN
    chk("ff_fan_first", fan_first, 18);
    chk("ff_fan_n", n_fan, 4);
    chk("ff_resp_cyc", resp_cyc[0], 22);
`else
    chk("ff_fan_n", n_fan, 0);
    chk("ff_resp_cyc", resp_cyc[0], 18);
`endif
    chk("ff_resp_n", n_resp, 1);

    // NOP leaves heading alone
    observe(16'h7FF1, 5, -1, 16'h0);
    chk("nop_clr_cyc", clr_cyc[0], 1);
    chk("nop_resp_cyc", resp_cyc[0], 2);
    chk("nop_heading", heading, 8'hA5);
    chk("nop_mov_n", n_mov, 0);
    chk("nop_sqd_n", n_sqd, 0);

    // MOVE with zero squares still loads heading
    observe(16'h2450, 5, -1, 16'h0);
    chk("z_heading", heading, 8'h45);
    chk("z_resp_cyc", resp_cyc[0], 2);
    chk("z_sqd_n", n_sqd, 0);
    chk("z_mov_n", n_mov, 0);

    // Second command raised mid-move waits for the next idle cycle
    observe(16'h2001, 16, 4, 16'h7001);
    chk("q_clr_n", n_clr, 2);
    chk("q_clr0", clr_cyc[0], 1);
    chk("q_clr1", clr_cyc[1], 12);
    chk("q_resp0", resp_cyc[0], 10);
    chk("q_resp1", resp_cyc[1], 13);
    chk("q_sqd0", sqd_cyc[0], 9);
    chk("q_heading", heading, 8'h00);

    // Asynchronous reset in the middle of a move
    cmd = 16'h2002;
    cmd_rdy = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cmd_rdy = 1'b0;
    @(negedge clk);
    chk("ar_moving_pre", moving, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_outputs", {clr_cmd_rdy, send_resp, moving, sq_done, fanfare, heading}, 0);
    cmd_rdy = 1'b1;
    any_act = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_act = any_act | clr_cmd_rdy | send_resp | moving | sq_done;
    end
    chk("ar_quiet", any_act, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    observe(16'h2002, 22, -1, 16'h0);
    chk("ar_clr_cyc", clr_cyc[0], 1);
    chk("ar_sqd_n", n_sqd, 2);
    chk("ar_sqd1", sqd_cyc[1], 17);
    chk("ar_resp_n", n_resp, 1);
    chk("ar_resp_cyc", resp_cyc[0], 18);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/move_cmd_exec.md
MOVE_CMD_EXEC -- requirements
Module: move_cmd_exec

Interface
REQ-001 Parameter SQ_CYCLES, default 16'd1000, clock cycles spent per square moved.
REQ-002 Parameter FANFARE_CYCLES, default 16'd500, clock cycles fanfare is held high.
REQ-003 clk  input  1  system clock, 50MHz, all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cmd  input  16  command word from TourCmd: [15:12] opcode, [11:4] heading, [3:0] squares.
REQ-006 cmd_rdy  input  1  level; high while cmd is valid and unconsumed.
REQ-007 clr_cmd_rdy  output  1  one-cycle pulse that consumes the command.
REQ-008 send_resp  output  1  one-cycle pulse that marks command completion.
REQ-009 moving  output  1  high during the MOVE state.
REQ-010 heading  output  8  heading register, loaded from cmd[11:4] on MOVE or MOVE_FF acceptance.
REQ-011 sq_done  output  1  one-cycle pulse at the end of each square.
REQ-012 fanfare  output  1  high during the FANFARE state.

Function
REQ-013 Opcodes: MOVE=4'h2, MOVE_FF=4'h3; every other opcode is a NOP.
REQ-014 States: IDLE, DECODE, MOVE, FANFARE, RESP; the state register is updated on each clk rising edge.
REQ-015 Cycle 0 is the first cycle in IDLE with cmd_rdy high; at its end the block latches cmd and enters DECODE.
REQ-016 clr_cmd_rdy is high in cycle 1 only (the DECODE cycle), and is never asserted outside DECODE.
REQ-017 cmd_rdy in any state other than IDLE is ignored; the command stays pending and is accepted on return to IDLE.
REQ-018 DECODE, NOP or squares==0: go to RESP, so send_resp is high in cycle 2; heading is unchanged for NOP.
REQ-019 DECODE, MOVE/MOVE_FF with squares>0: load heading, go to MOVE, moving is high in cycles 2 .. 1+squares*SQ_CYCLES.
REQ-020 In MOVE, a cycle counter 0..SQ_CYCLES-1 runs; at SQ_CYCLES-1 it pulses sq_done, wraps to 0 and decrements the remaining-squares count.
REQ-021 When the last square's sq_done fires: MOVE_FF with FANFARE_EN defined goes to FANFARE; otherwise it goes to RESP.
REQ-022 FANFARE lasts exactly FANFARE_CYCLES cycles, then goes to RESP.
REQ-023 RESP lasts exactly one cycle with send_resp high, then goes to IDLE.
REQ-024 A new command can be accepted in the cycle after RESP, which gives a minimum of 1 IDLE cycle between commands.
REQ-025 Counters are 16-bit and saturate-free; SQ_CYCLES and FANFARE_CYCLES shall be >=1.

Reset
REQ-026 rst_n low asynchronously forces IDLE and clears the counters and latched cmd.
REQ-027 While rst_n is low, outputs are: clr_cmd_rdy=0, send_resp=0, moving=0, heading=8'h00, sq_done=0, fanfare=0.
REQ-028 Reset mid-operation discards the command in flight and issues no send_resp; a still-high cmd_rdy is accepted afresh after release.

Configuration
REQ-029 Macro FANFARE_EN defined: MOVE_FF runs the FANFARE state after the move.
REQ-030 FANFARE_EN undefined: MOVE_FF behaves exactly as MOVE, fanfare is tied 0, and FANFARE logic is not compiled.

Structure
REQ-031 Shared package tour_pkg holds the opcode localparams, the cmd field positions and the state enum type.
REQ-032 The per-square and fanfare timing uses one sub-module, sq_timer: a loadable 16-bit down-counter with a terminal-count pulse.

Verification (SQ_CYCLES=8, FANFARE_CYCLES=4)
REQ-033 cmd=16'h2003, cmd_rdy held until clr -> clr_cmd_rdy in cycle 1, heading=8'h00, 3 sq_done pulses at cycles 9/17/25, send_resp in cycle 26.
REQ-034 cmd=16'h3A52 with FANFARE_EN -> heading=8'hA5, fanfare high in cycles 18-21, send_resp in cycle 22; without FANFARE_EN -> send_resp in cycle 18, fanfare always 0.
REQ-035 cmd=16'h7FF1 (NOP) -> clr_cmd_rdy in cycle 1, send_resp in cycle 2, heading unchanged, moving never high.
REQ-036 cmd=16'h2450, zero squares -> heading=8'h45, send_resp in cycle 2, no sq_done.
REQ-037 Second cmd_rdy raised during MOVE -> no clr_cmd_rdy until after send_resp, then accepted in the first IDLE cycle.
REQ-038 rst_n pulsed low during MOVE of 16'h2002 -> all outputs 0 immediately, no send_resp, clean restart afterward.
